vid_lock_mon: RTL and testbench

VID_LOCK_MON -- requirements
Module: vid_lock_mon

---
 rtl/vid_pkg.sv | 29 ++
 rtl/vid_sync.sv | 31 +++
 rtl/vid_lock_mon.sv | 141 ++++++++++++++
 tb/tb_vid_lock_mon.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/vid_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : vid_pkg
//  Description : Shared state encodings, parameter defaults and width helper
//                for the video PLL lock monitor.
//  Revision    : 1.0 - initial release
// ============================================================================
package vid_pkg;

   // Lock monitor FSM states; the encoding is visible on the state output.
   typedef enum logic [1:0] {
      ST_WAIT_LOCK = 2'd0,
      ST_SETTLE    = 2'd1,
      ST_RUN       = 2'd2,
      ST_LOST      = 2'd3
   } vid_state_e;

   localparam int unsigned SYNC_STAGES_DEF   = 2;
   localparam int unsigned SETTLE_CYCLES_DEF = 1024;
   localparam int unsigned HOLD_CYCLES_DEF   = 16;
   localparam int unsigned LOST_CNT_W        = 8;

   // Counter width for a count of n cycles: $clog2(n), never below one bit.
   function automatic int unsigned cnt_width(input int unsigned n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage : vid_pkg
`default_nettype wire

// File: rtl/vid_sync.sv
`default_nettype none
// ============================================================================
//  Module      : vid_sync
//  Description : Multi-flop synchronizer for a single asynchronous level.
//                All stages clear to 0 on asynchronous active-low reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module vid_sync #(
   parameter int unsigned STAGES = 2
) (
   input  logic clk,
   input  logic resetn,
   input  logic d_i,
   output logic q_o
);

   logic [STAGES-1:0] sync_q;

   // Shift the asynchronous input through the flop chain.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[STAGES-2:0], d_i};
      end
   end

   assign q_o = sync_q[STAGES-1];

endmodule : vid_sync
`default_nettype wire

// File: rtl/vid_lock_mon.sv
`default_nettype none
// ============================================================================
//  Module      : vid_lock_mon
//  Description : Video PLL lock monitor. Waits for a stable synchronized lock
//                before releasing the video-domain reset, and pulls the reset
//                back in for a minimum hold time on any lock loss. Keeps a
//                sticky loss flag and a saturating loss counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module vid_lock_mon
   import vid_pkg::*;
#(
   parameter int unsigned SYNC_STAGES   = SYNC_STAGES_DEF,
   parameter int unsigned SETTLE_CYCLES = SETTLE_CYCLES_DEF,
   parameter int unsigned HOLD_CYCLES   = HOLD_CYCLES_DEF
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic                  pll_locked,
   input  logic                  lost_clr,
   output logic                  rst_out_n,
   output logic                  ready,
   output logic [1:0]            state,
   output logic                  lost_sticky,
   output logic [LOST_CNT_W-1:0] lost_cnt
);

   localparam int unsigned SETTLE_W = cnt_width(SETTLE_CYCLES);
   localparam int unsigned HOLD_W   = cnt_width(HOLD_CYCLES);

   localparam logic [SETTLE_W-1:0]   SETTLE_LAST = SETTLE_W'(SETTLE_CYCLES - 1);
   localparam logic [HOLD_W-1:0]     HOLD_LAST   = HOLD_W'(HOLD_CYCLES - 1);
   localparam logic [SETTLE_W-1:0]   SETTLE_ONE  = SETTLE_W'(1);
   localparam logic [HOLD_W-1:0]     HOLD_ONE    = HOLD_W'(1);
   localparam logic [LOST_CNT_W-1:0] CNT_MAX     = '1;
   localparam logic [LOST_CNT_W-1:0] CNT_ONE     = LOST_CNT_W'(1);

   logic                  locked_s;
   vid_state_e            state_q,       state_d;
   logic [SETTLE_W-1:0]   settle_cnt_q,  settle_cnt_d;
   logic [HOLD_W-1:0]     hold_cnt_q,    hold_cnt_d;
   logic                  lost_sticky_q, lost_sticky_d;
   logic [LOST_CNT_W-1:0] lost_cnt_q,    lost_cnt_d;
   logic [LOST_CNT_W-1:0] lost_cnt_base;
   logic                  rst_out_n_q;
   logic                  ready_q;
   logic                  loss_evt;

   vid_sync #(
      .STAGES (SYNC_STAGES)
   ) u_sync (
      .clk    (clk),
      .resetn (resetn),
      .d_i    (pll_locked),
      .q_o    (locked_s)
   );

   // Next-state logic: settle and hold counters advance only in their states.
   always_comb begin
      state_d      = state_q;
      settle_cnt_d = settle_cnt_q;
      hold_cnt_d   = hold_cnt_q;
      loss_evt     = 1'b0;
      case (state_q)
         ST_WAIT_LOCK: begin
            if (locked_s) begin
               state_d      = ST_SETTLE;
               settle_cnt_d = '0;
            end
         end
         ST_SETTLE: begin
            // A drop while settling is just an unstable lock, not a loss.
            if (!locked_s) begin
               state_d = ST_WAIT_LOCK;
            end else if (settle_cnt_q == SETTLE_LAST) begin
               state_d = ST_RUN;
            end else begin
               settle_cnt_d = settle_cnt_q + SETTLE_ONE;
            end
         end
         ST_RUN: begin
            if (!locked_s) begin
               state_d    = ST_LOST;
               hold_cnt_d = '0;
               loss_evt   = 1'b1;
            end
         end
         ST_LOST: begin
            // Hold time is fixed; locked_s is ignored until it expires.
            if (hold_cnt_q == HOLD_LAST) begin
               state_d = ST_WAIT_LOCK;
            end else begin
               hold_cnt_d = hold_cnt_q + HOLD_ONE;
            end
         end
         default: state_d = ST_WAIT_LOCK;
      endcase
   end

   // Loss bookkeeping: clear is applied first so a coincident loss still lands.
   always_comb begin
      lost_sticky_d = lost_clr ? 1'b0 : lost_sticky_q;
      lost_cnt_base = lost_clr ? '0   : lost_cnt_q;
      lost_cnt_d    = lost_cnt_base;
      if (loss_evt) begin
         lost_sticky_d = 1'b1;
         if (lost_cnt_base != CNT_MAX) begin
            lost_cnt_d = lost_cnt_base + CNT_ONE;
         end
      end
   end

   // State, counters and outputs; outputs decode next state to align edges.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q       <= ST_WAIT_LOCK;
         settle_cnt_q  <= '0;
         hold_cnt_q    <= '0;
         lost_sticky_q <= 1'b0;
         lost_cnt_q    <= '0;
         rst_out_n_q   <= 1'b0;
         ready_q       <= 1'b0;
      end else begin
         state_q       <= state_d;
         settle_cnt_q  <= settle_cnt_d;
         hold_cnt_q    <= hold_cnt_d;
         lost_sticky_q <= lost_sticky_d;
         lost_cnt_q    <= lost_cnt_d;
         rst_out_n_q   <= (state_d == ST_RUN);
         ready_q       <= (state_d == ST_RUN);
      end
   end

   assign rst_out_n   = rst_out_n_q;
   assign ready       = ready_q;
   assign state       = state_q;
   assign lost_sticky = lost_sticky_q;
   assign lost_cnt    = lost_cnt_q;

endmodule : vid_lock_mon
`default_nettype wire

// File: tb/tb_vid_lock_mon.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vid_lock_mon
//  Description : Directed self-checking bench for vid_lock_mon with
//                SYNC_STAGES=2, SETTLE_CYCLES=16, HOLD_CYCLES=16.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_vid_lock_mon;

   logic       clk = 1'b0;
   logic       resetn;
   logic       pll_locked;
   logic       lost_clr;
   logic       rst_out_n;
   logic       ready;
   logic [1:0] state;
   logic       lost_sticky;
   logic [7:0] lost_cnt;

   int checks = 0;
   int errors = 0;

   vid_lock_mon #(
      .SYNC_STAGES   (2),
      .SETTLE_CYCLES (16),
      .HOLD_CYCLES   (16)
   ) dut (
      .clk         (clk),
      .resetn      (resetn),
      .pll_locked  (pll_locked),
      .lost_clr    (lost_clr),
      .rst_out_n   (rst_out_n),
      .ready       (ready),
      .state       (state),
      .lost_sticky (lost_sticky),
      .lost_cnt    (lost_cnt)
   );

   always #5 clk = ~clk;

   // Advance n rising edges and land 1 time unit after the last one.
   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      resetn     = 1'b0;
      pll_locked = 1'b0;
      lost_clr   = 1'b0;
      tick(2);
      resetn = 1'b1;
   endtask

   // Lock is sampled high on the next edge; RUN is reached on the 19th.
   task automatic acquire();
      pll_locked = 1'b1;
      tick(19);
   endtask

   task automatic test_reset();
      resetn     = 1'b0;
      pll_locked = 1'b1;
      lost_clr   = 1'b0;
      tick(3);
      checks++; if (rst_out_n !== 1'b0) begin errors++; $display("FAIL reset_rst_out_n got %0b want 0", rst_out_n); end
      checks++; if (ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %0b want 0", ready); end
      checks++; if (state !== 2'd0) begin errors++; $display("FAIL reset_state got %0d want 0", state); end
      checks++; if (lost_sticky !== 1'b0) begin errors++; $display("FAIL reset_sticky got %0b want 0", lost_sticky); end
      checks++; if (lost_cnt !== 8'd0) begin errors++; $display("FAIL reset_cnt got %0d want 0", lost_cnt); end
   endtask

   task automatic test_acquire();
      do_reset();
      pll_locked = 1'b1;
      tick(2);
      checks++; if (state !== 2'd0) begin errors++; $display("FAIL acq_e2_state got %0d want 0", state); end
      tick(1);
      checks++; if (state !== 2'd1) begin errors++; $display("FAIL acq_e3_state got %0d want 1", state); end
      tick(15);
      checks++; if (state !== 2'd1) begin errors++; $display("FAIL acq_e18_state got %0d want 1", state); end
      checks++; if (rst_out_n !== 1'b0) begin errors++; $display("FAIL acq_e18_rst got %0b want 0", rst_out_n); end
      tick(1);
      checks++; if (rst_out_n !== 1'b1) begin errors++; $display("FAIL acq_e19_rst got %0b want 1", rst_out_n); end
      checks++; if (ready !== 1'b1) begin errors++; $display("FAIL acq_e19_ready got %0b want 1", ready); end
      checks++; if (state !== 2'd2) begin errors++; $display("FAIL acq_e19_state got %0d want 2", state); end
   endtask

   task automatic test_glitch_settle();
      do_reset();
      pll_locked = 1'b1;
      tick(13);   // settle count is 10 here
      checks++; if (state !== 2'd1) begin errors++; $display("FAIL glitch_pre_state got %0d want 1", state); end
      pll_locked = 1'b0;
      tick(3);
      checks++; if (state !== 2'd0) begin errors++; $display("FAIL glitch_wait_state got %0d want 0", state); end
      checks++; if (lost_cnt !== 8'd0) begin errors++; $display("FAIL glitch_cnt got %0d want 0", lost_cnt); end
      checks++; if (lost_sticky !== 1'b0) begin errors++; $display("FAIL glitch_sticky got %0b want 0", lost_sticky); end
      pll_locked = 1'b1;
      tick(18);
      checks++; if (rst_out_n !== 1'b0) begin errors++; $display("FAIL glitch_resettle18_rst got %0b want 0", rst_out_n); end
      checks++; if (state !== 2'd1) begin errors++; $display("FAIL glitch_resettle18_state got %0d want 1", state); end
      tick(1);
      checks++; if (rst_out_n !== 1'b1) begin errors++; $display("FAIL glitch_resettle19_rst got %0b want 1", rst_out_n); end
   endtask

   task automatic test_loss_run();
      do_reset();
      acquire();
      pll_locked = 1'b0;
      tick(1);
      pll_locked = 1'b1;
      tick(1);
      checks++; if (rst_out_n !== 1'b1) begin errors++; $display("FAIL loss_e2_rst got %0b want 1", rst_out_n); end
      tick(1);
      checks++; if (rst_out_n !== 1'b0) begin errors++; $display("FAIL loss_e3_rst got %0b want 0", rst_out_n); end
      checks++; if (ready !== 1'b0) begin errors++; $display("FAIL loss_e3_ready got %0b want 0", ready); end
      checks++; if (state !== 2'd3) begin errors++; $display("FAIL loss_e3_state got %0d want 3", state); end
      checks++; if (lost_sticky !== 1'b1) begin errors++; $display("FAIL loss_sticky got %0b want 1", lost_sticky); end
      checks++; if (lost_cnt !== 8'd1) begin errors++; $display("FAIL loss_cnt got %0d want 1", lost_cnt); end
      tick(15);
      checks++; if (state !== 2'd3) begin errors++; $display("FAIL loss_hold_end_state got %0d want 3", state); end
      tick(1);
      checks++; if (state !== 2'd0) begin errors++; $display("FAIL loss_hold_exit_state got %0d want 0", state); end
      tick(1);
      checks++; if (state !== 2'd1) begin errors++; $display("FAIL loss_resettle_state got %0d want 1", state); end
      tick(15);
      checks++; if (rst_out_n !== 1'b0) begin errors++; $display("FAIL loss_reacq_pre_rst got %0b want 0", rst_out_n); end
      tick(1);
      checks++; if (rst_out_n !== 1'b1) begin errors++; $display("FAIL loss_reacq_rst got %0b want 1", rst_out_n); end
      checks++; if (state !== 2'd2) begin errors++; $display("FAIL loss_reacq_state got %0d want 2", state); end
   endtask

   task automatic test_saturation();
      int n;
      do_reset();
      acquire();
      for (int i = 0; i < 300; i++) begin
         pll_locked = 1'b0;
         tick(1);
         pll_locked = 1'b1;
         n = 0;
         while (ready === 1'b1 && n < 10) begin tick(1); n++; end
         n = 0;
         while (ready !== 1'b1 && n < 60) begin tick(1); n++; end
         checks++; if (ready !== 1'b1) begin errors++; $display("FAIL sat_relock_%0d got ready %0b want 1", i, ready); end
         if (i == 9) begin
            checks++; if (lost_cnt !== 8'd10) begin errors++; $display("FAIL sat_cnt10 got %0d want 10", lost_cnt); end
         end
      end
      checks++; if (lost_cnt !== 8'd255) begin errors++; $display("FAIL sat_cnt got %0d want 255", lost_cnt); end
      checks++; if (lost_sticky !== 1'b1) begin errors++; $display("FAIL sat_sticky got %0b want 1", lost_sticky); end
      lost_clr = 1'b1;
      tick(1);
      lost_clr = 1'b0;
      checks++; if (lost_cnt !== 8'd0) begin errors++; $display("FAIL clr_cnt got %0d want 0", lost_cnt); end
      checks++; if (lost_sticky !== 1'b0) begin errors++; $display("FAIL clr_sticky got %0b want 0", lost_sticky); end
      checks++; if (ready !== 1'b1) begin errors++; $display("FAIL clr_ready got %0b want 1", ready); end
   endtask

   task automatic test_simultaneous();
      int n;
      do_reset();
      acquire();
      pll_locked = 1'b0;
      tick(1);
      pll_locked = 1'b1;
      n = 0;
      while (ready === 1'b1 && n < 10) begin tick(1); n++; end
      n = 0;
      while (ready !== 1'b1 && n < 60) begin tick(1); n++; end
      checks++; if (lost_cnt !== 8'd1) begin errors++; $display("FAIL simul_pre_cnt got %0d want 1", lost_cnt); end
      pll_locked = 1'b0;
      tick(2);
      lost_clr = 1'b1;
      tick(1);
      lost_clr = 1'b0;
      checks++; if (state !== 2'd3) begin errors++; $display("FAIL simul_state got %0d want 3", state); end
      checks++; if (lost_sticky !== 1'b1) begin errors++; $display("FAIL simul_sticky got %0b want 1", lost_sticky); end
      checks++; if (lost_cnt !== 8'd1) begin errors++; $display("FAIL simul_cnt got %0d want 1", lost_cnt); end
      pll_locked = 1'b1;
   endtask

   task automatic test_async_reset();
      do_reset();
      acquire();
      pll_locked = 1'b0;
      tick(1);
      pll_locked = 1'b1;
      tick(40);   // back in RUN with one loss recorded
      checks++; if (ready !== 1'b1 || lost_cnt !== 8'd1) begin errors++; $display("FAIL async_pre got ready %0b cnt %0d want 1 1", ready, lost_cnt); end
      #3;
      resetn = 1'b0;
      #1;
      checks++; if (rst_out_n !== 1'b0) begin errors++; $display("FAIL async_rst got %0b want 0", rst_out_n); end
      checks++; if (ready !== 1'b0) begin errors++; $display("FAIL async_ready got %0b want 0", ready); end
      checks++; if (state !== 2'd0) begin errors++; $display("FAIL async_state got %0d want 0", state); end
      checks++; if (lost_sticky !== 1'b0) begin errors++; $display("FAIL async_sticky got %0b want 0", lost_sticky); end
      checks++; if (lost_cnt !== 8'd0) begin errors++; $display("FAIL async_cnt got %0d want 0", lost_cnt); end
      #2;
      resetn = 1'b1;
      tick(18);
      checks++; if (rst_out_n !== 1'b0) begin errors++; $display("FAIL async_reacq18_rst got %0b want 0", rst_out_n); end
      checks++; if (state !== 2'd1) begin errors++; $display("FAIL async_reacq18_state got %0d want 1", state); end
      tick(1);
      checks++; if (rst_out_n !== 1'b1) begin errors++; $display("FAIL async_reacq19_rst got %0b want 1", rst_out_n); end
      checks++; if (state !== 2'd2) begin errors++; $display("FAIL async_reacq19_state got %0d want 2", state); end
   endtask

   initial begin
      test_reset();
      test_acquire();
      test_glitch_settle();
      test_loss_run();
      test_saturation();
      test_simultaneous();
      test_async_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Watchdog so the run always terminates.
   initial begin
      #2000000;
      $display("FAIL watchdog_timeout got running want finished");
      $fatal(1, "watchdog expired");
   end

endmodule : tb_vid_lock_mon
`default_nettype wire
